// File: rtl/dvbc_rs_pkg.sv
// Shared GF(2^8) definitions for the DVB-C RS(204,188) encoder and syndrome checker.
// Field polynomial 0x11D, alpha = 0x02, generator roots alpha^0..alpha^15.
package dvbc_rs_pkg;

  localparam int RS_N    = 204;
  localparam int RS_NSYN = 16;

  localparam logic [8:0] GF_POLY = 9'h11D;

  // alpha^j for j = 0..15.
  localparam logic [7:0] ALPHA_POW [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1d, 8'h3a, 8'h74, 8'he8, 8'hcd, 8'h87, 8'h13, 8'h26
  };

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // With c constant the loop folds away, leaving a pure XOR network on x.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] c, input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] a;
    acc = '0;
    a   = x;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/dvbc_rs_syndrome_check_if.sv
// Byte-stream input and packet-result output of the RS syndrome checker.
// Handshake: in_valid qualifies in_sop/in_data every cycle, no backpressure; out_valid is a one-cycle pulse.
interface dvbc_rs_syndrome_check_if #(
  parameter int NSYN  = 16,
  parameter int CNT_W = 16
) ();
  logic                in_valid;
  logic                in_sop;
  logic [7:0]          in_data;
  logic                out_valid;
  logic                out_err;
  logic [8*NSYN-1:0]   out_syn;
  logic [CNT_W-1:0]    err_cnt;
  logic                frm_err;

  modport master (
    output in_valid, in_sop, in_data,
    input  out_valid, out_err, out_syn, err_cnt, frm_err
  );

  modport slave (
    input  in_valid, in_sop, in_data,
    output out_valid, out_err, out_syn, err_cnt, frm_err
  );
endinterface

// File: rtl/dvbc_rs_syn_cell.sv
// One syndrome accumulator S_J, updated by Horner's rule: S <= S*alpha^J ^ b.
// syn_next_o is the value the register takes at the coming edge.
module dvbc_rs_syn_cell
  import dvbc_rs_pkg::*;
#(
  parameter int J = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] data_i,
  output logic [7:0] syn_next_o
);

  logic [7:0] syn_q;
  logic [7:0] syn_d;

  always_comb begin
    syn_d = syn_q;
    if (load_i) begin
      syn_d = data_i;
    end else if (shift_i) begin
      syn_d = gf_mul_const(ALPHA_POW[J], syn_q) ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_q <= '0;
    end else begin
      syn_q <= syn_d;
    end
  end

  assign syn_next_o = syn_d;

endmodule

// File: rtl/dvbc_rs_syndrome_check.sv
// RS(204,188) receive-side checker: framing FSM, byte counter, NSYN syndrome cells,
// registered per-packet result, saturating errored-packet counter and framing-error pulse.
module dvbc_rs_syndrome_check
  import dvbc_rs_pkg::*;
#(
  parameter int N     = RS_N,
  parameter int NSYN  = RS_NSYN,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dvbc_rs_syndrome_check_if.slave   bus,
  output state_e                    dbg_state_o
);

  localparam int CW = $clog2(N + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              load, shift, done, frm_d;
  logic [8*NSYN-1:0] syn_next;

  logic              out_valid_q;
  logic              out_err_q;
  logic [8*NSYN-1:0] out_syn_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic              frm_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    frm_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_sop) begin
            load    = 1'b1;
            cnt_d   = CW'(1);
            state_d = ST_COLLECT;
          end else begin
            frm_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (bus.in_valid) begin
          // An SOP inside a packet, even on its last byte, restarts collection.
          if (bus.in_sop) begin
            frm_d = 1'b1;
            load  = 1'b1;
            cnt_d = CW'(1);
          end else begin
            shift = 1'b1;
            if (cnt_q == CW'(N - 1)) begin
              done    = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar j = 0; j < NSYN; j++) begin : g_syn
    dvbc_rs_syn_cell #(.J(j)) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .shift_i    (shift),
      .data_i     (bus.in_data),
      .syn_next_o (syn_next[8*j +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_syn_q   <= '0;
      err_cnt_q   <= '0;
      frm_err_q   <= 1'b0;
    end else begin
      out_valid_q <= done;
      frm_err_q   <= frm_d;
      if (done) begin
        out_syn_q <= syn_next;
        out_err_q <= |syn_next;
      end
      if (out_valid_q && out_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_syn   = out_syn_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.frm_err   = frm_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dvbc_rs_syndrome_check.sv
// Directed bench for dvbc_rs_syndrome_check with a log/antilog GF model, RS encoder model
// and an expected-result queue; a CNT_W=4 twin shares the same input stream.
module tb_dvbc_rs_syndrome_check;
  import dvbc_rs_pkg::*;

  localparam int N  = RS_N;
  localparam int NS = RS_NSYN;
  localparam int SW = 8 * NS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dvbc_rs_syndrome_check_if #(.NSYN(NS), .CNT_W(16)) bus ();
  dvbc_rs_syndrome_check_if #(.NSYN(NS), .CNT_W(4))  bus_s ();
  state_e dbg_state, dbg_state_s;

  dvbc_rs_syndrome_check #(.N(N), .NSYN(NS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state_o(dbg_state)
  );
  dvbc_rs_syndrome_check #(.N(N), .NSYN(NS), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s.slave), .dbg_state_o(dbg_state_s)
  );

  assign bus_s.in_valid = bus.in_valid;
  assign bus_s.in_sop   = bus.in_sop;
  assign bus_s.in_data  = bus.in_data;

  // ---------------- model ----------------
  logic [7:0] gexp [255];
  int         glog [256];
  logic [7:0] gen [17];
  logic [7:0] pkt [N];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [8:0] x;
    x = 9'h001;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x[7:0];
      glog[x[7:0]] = i;
      x = {x[7:0], 1'b0};
      if (x[8]) x = x ^ 9'h11D;
    end
    for (int k = 0; k < 17; k++) gen[k] = 8'h00;
    gen[0] = 8'h01;
    for (int i = 0; i < NS; i++) begin
      for (int k = i + 1; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], gexp[i]);
      gen[0] = gmul(gen[0], gexp[i]);
    end
  endtask

  // Direct evaluation S_j = sum r_i * alpha^(j*(N-1-i)).
  function automatic logic [SW-1:0] model_syn();
    logic [SW-1:0] s;
    logic [7:0]    acc;
    s = '0;
    for (int j = 0; j < NS; j++) begin
      acc = 8'h00;
      for (int i = 0; i < N; i++)
        if (pkt[i] != 0) acc = acc ^ gexp[(glog[pkt[i]] + j * (N - 1 - i)) % 255];
      s[8*j +: 8] = acc;
    end
    return s;
  endfunction

  task automatic fill_zero();
    for (int i = 0; i < N; i++) pkt[i] = 8'h00;
  endtask

  task automatic fill_codeword();
    logic [7:0] p [16];
    logic [7:0] fb;
    for (int k = 0; k < 16; k++) p[k] = 8'h00;
    for (int i = 0; i < N - NS; i++) begin
      pkt[i] = 8'($urandom_range(255));
      fb = pkt[i] ^ p[15];
      for (int k = 15; k >= 1; k--) p[k] = p[k-1] ^ gmul(fb, gen[k]);
      p[0] = gmul(fb, gen[0]);
    end
    for (int k = 0; k < NS; k++) pkt[N - NS + k] = p[15 - k];
  endtask

  // ---------------- scoreboard ----------------
  logic [SW:0] exp_q [$];
  int          cyc_q [$];
  int n_vec = 0;
  int n_mis = 0;
  int n_err = 0;
  int frm_exp = 0;
  int frm_seen = 0;

  task automatic check(input string tag, input logic [SW:0] obs, input logic [SW:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frm_err) frm_seen++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1'b1, 1'b0);
        end else begin
          logic [SW:0] e;
          int          c;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("out_syn", bus.out_syn, e[SW-1:0]);
          check("out_err", bus.out_err, e[SW]);
          check("out_valid_cycle", cyc, c);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sop   = s;
    bus.in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_bytes(input int first, input int last, input int gap_pct);
    for (int i = first; i <= last; i++) begin
      while (int'($urandom_range(99)) < gap_pct) drive(1'b0, 1'b0, 8'($urandom_range(255)));
      drive(1'b1, i == 0, pkt[i]);
    end
  endtask

  task automatic send_pkt(input int gap_pct);
    logic [SW-1:0] s;
    send_bytes(0, N - 1, gap_pct);
    s = model_syn();
    exp_q.push_back({|s, s});
    cyc_q.push_back(cyc + 1);
    if (|s) n_err++;
  endtask

  task automatic check_status(input string tag);
    idle(3);
    check({tag, "_err_cnt"}, bus.err_cnt, (n_err > 65535) ? 65535 : n_err);
    check({tag, "_err_cnt4"}, bus_s.err_cnt, (n_err > 15) ? 15 : n_err);
    check({tag, "_frm_err_pulses"}, frm_seen, frm_exp);
    check({tag, "_pending_results"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_err"}, bus.out_err, 1'b0);
    check({tag, "_out_syn"}, bus.out_syn, '0);
    check({tag, "_err_cnt"}, bus.err_cnt, '0);
    check({tag, "_err_cnt4"}, bus_s.err_cnt, '0);
    check({tag, "_frm_err"}, bus.frm_err, 1'b0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_data  = 8'h00;
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // all-zero codeword
    fill_zero();
    send_pkt(0);
    check_status("zeros");

    // three valid codewords back to back, full throughput
    for (int k = 0; k < 3; k++) begin
      fill_codeword();
      send_pkt(0);
    end
    check_status("codeword_x3");

    // single error in the last byte: every S_j = 0x01
    fill_zero();
    pkt[N-1] = 8'h01;
    send_pkt(0);
    check_status("last_byte_01");

    // error in the first byte, once without and once with input gaps
    fill_zero();
    pkt[0] = 8'h5A;
    send_pkt(0);
    send_pkt(40);
    check_status("first_byte_5a");

    // SOP at byte 100 aborts, then a full valid packet
    fill_codeword();
    send_bytes(0, 99, 0);
    fill_codeword();
    frm_exp++;
    send_pkt(0);
    check_status("early_sop");

    // SOP arriving in place of the last byte also aborts
    fill_codeword();
    send_bytes(0, N - 2, 0);
    fill_codeword();
    frm_exp++;
    send_pkt(10);
    check_status("sop_at_last");

    // stray byte while idle
    drive(1'b1, 1'b0, 8'h33);
    frm_exp++;
    check_status("stray_byte");

    // reset in the middle of a packet
    fill_codeword();
    send_bytes(0, 49, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    n_err = 0;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    fill_codeword();
    send_pkt(0);
    check_status("after_reset");

    // 17 errored packets: 4-bit counter saturates at 15
    for (int k = 0; k < 17; k++) begin
      fill_zero();
      pkt[$urandom_range(N - 1)] = 8'($urandom_range(1, 255));
      send_pkt(0);
    end
    check_status("saturate");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
